// File: rtl/zc_pkg.sv
// Shared zero-counting helpers and width constants for datapath blocks.
// Functions take a 64-bit word plus its live width, so one copy serves every WIDTH.
package zc_pkg;

    localparam int ZC_WIDTH = 8;
    localparam int ZC_MAX_W = 64;

    function automatic int clog2w(input int width);
        return $clog2(width + 1);
    endfunction

    function automatic logic [6:0] count_zeros(input logic [ZC_MAX_W-1:0] d, input int w);
        logic [6:0] n;
        n = '0;
        for (int i = 0; i < ZC_MAX_W; i++) begin
            if (i < w && !d[i]) n = n + 7'd1;
        end
        return n;
    endfunction

    function automatic logic [6:0] lead_zeros(input logic [ZC_MAX_W-1:0] d, input int w);
        logic [6:0] n;
        logic       hit;
        n   = '0;
        hit = 1'b0;
        for (int i = ZC_MAX_W - 1; i >= 0; i--) begin
            if (i < w && !hit) begin
                if (d[i]) hit = 1'b1;
                else      n   = n + 7'd1;
            end
        end
        return n;
    endfunction

    function automatic logic [6:0] trail_zeros(input logic [ZC_MAX_W-1:0] d, input int w);
        logic [6:0] n;
        logic       hit;
        n   = '0;
        hit = 1'b0;
        for (int i = 0; i < ZC_MAX_W; i++) begin
            if (i < w && !hit) begin
                if (d[i]) hit = 1'b1;
                else      n   = n + 7'd1;
            end
        end
        return n;
    endfunction

endpackage

// File: rtl/zero_count_reg.sv
// Output register bank for the zero counter: load-enabled counts and flags,
// free-running valid, all cleared asynchronously by rst_n.
module zero_count_reg #(
    parameter int CW = 4
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          en_i,
    input  logic [CW-1:0] zc_d,
    input  logic [CW-1:0] lzc_d,
    input  logic [CW-1:0] tzc_d,
    input  logic          az_d,
    input  logic          ao_d,
    output logic [CW-1:0] zc_o,
    output logic [CW-1:0] lzc_o,
    output logic [CW-1:0] tzc_o,
    output logic          az_o,
    output logic          ao_o,
    output logic          vld_o
);

    logic [CW-1:0] zc_q, lzc_q, tzc_q;
    logic          az_q, ao_q, vld_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            zc_q  <= '0;
            lzc_q <= '0;
            tzc_q <= '0;
            az_q  <= 1'b0;
            ao_q  <= 1'b0;
        end else if (en_i) begin
            zc_q  <= zc_d;
            lzc_q <= lzc_d;
            tzc_q <= tzc_d;
            az_q  <= az_d;
            ao_q  <= ao_d;
        end
    end

    // Valid follows the enable every edge, independent of the load.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) vld_q <= 1'b0;
        else        vld_q <= en_i;
    end

    assign zc_o  = zc_q;
    assign lzc_o = lzc_q;
    assign tzc_o = tzc_q;
    assign az_o  = az_q;
    assign ao_o  = ao_q;
    assign vld_o = vld_q;

endmodule

// File: rtl/zero_count_function.sv
// Zero-bit population counter: combinational count plus a registered copy
// with leading/trailing zero counts and all-zero/all-one flags.
module zero_count_function
    import zc_pkg::*;
#(
    parameter  int WIDTH = ZC_WIDTH,
    localparam int CW    = clog2w(WIDTH)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] data,
    input  logic             in_valid,
    output logic [CW-1:0]    out,
    output logic [CW-1:0]    out_q,
    output logic [CW-1:0]    lzc_q,
    output logic [CW-1:0]    tzc_q,
    output logic             all_zero,
    output logic             all_one,
    output logic             out_valid
);

    logic [ZC_MAX_W-1:0] data_ext;
    logic [CW-1:0]       zc_c, lzc_c, tzc_c;

    assign data_ext = ZC_MAX_W'(data);
    // CW holds WIDTH exactly, so the truncation never drops a set bit.
    assign zc_c  = CW'(count_zeros(data_ext, WIDTH));
    assign lzc_c = CW'(lead_zeros(data_ext, WIDTH));
    assign tzc_c = CW'(trail_zeros(data_ext, WIDTH));
    assign out   = zc_c;

    zero_count_reg #(.CW(CW)) u_reg (
        .clk   (clk),
        .rst_n (rst_n),
        .en_i  (in_valid),
        .zc_d  (zc_c),
        .lzc_d (lzc_c),
        .tzc_d (tzc_c),
        .az_d  (zc_c == CW'(WIDTH)),
        .ao_d  (zc_c == '0),
        .zc_o  (out_q),
        .lzc_o (lzc_q),
        .tzc_o (tzc_q),
        .az_o  (all_zero),
        .ao_o  (all_one),
        .vld_o (out_valid)
    );

endmodule

// File: tb/tb_zero_count_function.sv
// Scoreboard bench for zero_count_function at WIDTH=8: stimulus pushes expected
// registered results, a monitor pops and compares whenever out_valid is high.
module tb_zero_count_function;

    typedef struct {
        int zc;
        int lzc;
        int tzc;
        bit az;
        bit ao;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [7:0] data = 8'h00;
    logic       in_valid = 1'b0;
    logic [3:0] out_w, out_q, lzc_q, tzc_q;
    logic       all_zero, all_one, out_valid;

    int   n_cmp = 0;
    int   n_bad = 0;
    exp_t sb_q[$];
    exp_t held;

    always #5 clk = ~clk;

    zero_count_function #(.WIDTH(8)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .data      (data),
        .in_valid  (in_valid),
        .out       (out_w),
        .out_q     (out_q),
        .lzc_q     (lzc_q),
        .tzc_q     (tzc_q),
        .all_zero  (all_zero),
        .all_one   (all_one),
        .out_valid (out_valid)
    );

    // Reference: popcount for zeros, log2 of the MSB / isolated LSB for lzc/tzc.
    function automatic exp_t model(input logic [7:0] d);
        exp_t e;
        int   di;
        di   = int'(d);
        e.zc = 8 - $countones(d);
        if (di == 0) begin
            e.lzc = 8;
            e.tzc = 8;
        end else begin
            e.lzc = 8 - $clog2(di + 1);
            e.tzc = $clog2(di & -di);
        end
        e.az = (di == 0);
        e.ao = (di == 255);
        return e;
    endfunction

    task automatic chk(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic chk_regs(input string tag, input exp_t e);
        chk({tag, " out_q"}, int'(out_q), e.zc);
        chk({tag, " lzc_q"}, int'(lzc_q), e.lzc);
        chk({tag, " tzc_q"}, int'(tzc_q), e.tzc);
        chk({tag, " all_zero"}, int'(all_zero), int'(e.az));
        chk({tag, " all_one"}, int'(all_one), int'(e.ao));
    endtask

    task automatic drive(input logic [7:0] d, input logic v);
        @(negedge clk);
        data     = d;
        in_valid = v;
        #1;
        chk("comb out", int'(out_w), 8 - $countones(d));
        if (v && rst_n) sb_q.push_back(model(d));
    endtask

    // Monitor: one cycle after each capture edge, compare or check hold.
    initial begin
        held = '{0, 0, 0, 1'b0, 1'b0};
        forever begin
            @(posedge clk);
            #1;
            if (rst_n) begin
                if (out_valid) begin
                    if (sb_q.size() == 0) begin
                        chk("unexpected out_valid", 1, 0);
                    end else begin
                        held = sb_q.pop_front();
                        chk_regs("capture", held);
                    end
                end else begin
                    chk_regs("hold", held);
                end
            end
        end
    end

    logic [7:0] therm [9];
    initial begin
        therm = '{8'h00, 8'h01, 8'h03, 8'h07, 8'h0F, 8'h1F, 8'h3F, 8'h7F, 8'hFF};

        // Reset state
        #12;
        chk("reset out_valid", int'(out_valid), 0);
        chk_regs("reset", '{0, 0, 0, 1'b0, 1'b0});

        // Thermometer sweep on the combinational path, 10 ns steps
        for (int i = 0; i < 9; i++) begin
            data = therm[i];
            #1;
            chk("therm out", int'(out_w), 8 - i);
            #9;
        end

        @(negedge clk);
        rst_n = 1'b1;

        // Registered capture
        drive(8'b0001_0000, 1'b1);
        drive(8'h00, 1'b1);
        drive(8'hFF, 1'b1);
        // Hold: out follows data, registers keep 8'hFF results
        drive(8'hA5, 1'b0);
        drive(8'hA5, 1'b0);

        // Alternating patterns
        drive(8'h55, 1'b1);
        drive(8'hAA, 1'b1);
        drive(8'hAA, 1'b0);

        // Async reset between edges with a capture pending
        drive(8'h3C, 1'b1);
        #2;
        rst_n = 1'b0;
        sb_q.delete();
        held = '{0, 0, 0, 1'b0, 1'b0};
        #1;
        chk("async rst out_valid", int'(out_valid), 0);
        chk_regs("async rst", held);
        data = 8'h81;
        #1;
        chk("comb out in reset", int'(out_w), 6);
        @(posedge clk);
        #1;
        chk("rst held out_valid", int'(out_valid), 0);
        chk_regs("rst held", held);
        @(negedge clk);
        in_valid = 1'b0;
        rst_n    = 1'b1;

        // Random words with random in_valid
        for (int i = 0; i < 1000; i++) begin
            drive(8'($urandom_range(0, 255)), 1'($urandom_range(0, 1)));
        end
        drive(8'h00, 1'b0);

        // Drain, bounded
        for (int i = 0; i < 10 && sb_q.size() != 0; i++) @(negedge clk);
        if (sb_q.size() != 0) chk("scoreboard drain", sb_q.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
